alu_issue_stage: RTL and testbench

//   ID/EX issue stage that drives the ALU: decodes a RV32I instruction plus register-file operands

---
 rtl/alu_pkg.sv | 58 +++++
 rtl/alu_issue_decode.sv | 99 +++++++++
 rtl/alu_issue_stage.sv | 107 ++++++++++
 tb/tb_alu_issue_stage.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue stage.
//   - alu_ctrl_e    : 3-bit ALU control codes (011 is never emitted)
//   - OP_*          : RV32I major opcodes recognised by the issue decoder
//   - issue_entry_t : one buffered instruction, i.e. every out_* data field
//   - f3_to_ctrl    : funct3 -> ALU code mapping shared by OP and OP-IMM
package alu_pkg;

  localparam int unsigned DATA_W = 32;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SLL = 3'b001,
    ALU_SUB = 3'b010,
    ALU_XOR = 3'b100,
    ALU_SRL = 3'b101,
    ALU_OR  = 3'b110,
    ALU_AND = 3'b111
  } alu_ctrl_e;

  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;

  typedef struct packed {
    logic [DATA_W-1:0] in_a;
    logic [DATA_W-1:0] in_b;
    alu_ctrl_e         control;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] rs2_data;
    logic [4:0]        rd;
    logic              rd_we;
    logic [2:0]        cmp_mode;
    logic              sra;
    logic              illegal;
  } issue_entry_t;

  // SLT/SLTU use SUB; EX resolves the comparison from cmp_mode.
  function automatic alu_ctrl_e f3_to_ctrl(input logic [2:0] f3, input logic sub);
    alu_ctrl_e c;
    case (f3)
      3'b000:         c = sub ? ALU_SUB : ALU_ADD;
      3'b001:         c = ALU_SLL;
      3'b010, 3'b011: c = ALU_SUB;
      3'b100:         c = ALU_XOR;
      3'b101:         c = ALU_SRL;
      3'b110:         c = ALU_OR;
      default:        c = ALU_AND;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/alu_issue_decode.sv
// Combinational decoder: instruction word, PC and register operands ->
// one issue_entry_t (ALU operands, control code and EX/WB side fields).
//   inst      : raw 32-bit instruction
//   pc        : instruction PC
//   rs1_data  : forwarded rs1 value
//   rs2_data  : forwarded rs2 value
//   entry     : decoded entry
module alu_issue_decode
  import alu_pkg::*;
(
  input  logic [31:0]        inst,
  input  logic [DATA_W-1:0]  pc,
  input  logic [DATA_W-1:0]  rs1_data,
  input  logic [DATA_W-1:0]  rs2_data,
  output issue_entry_t       entry
);

  logic [6:0]        opcode;
  logic [4:0]        rd;
  logic [2:0]        f3;
  logic              f7_5;
  logic [DATA_W-1:0] imm_i;
  logic [DATA_W-1:0] imm_s;
  logic [DATA_W-1:0] imm_u;
  logic              wr;

  assign opcode = inst[6:0];
  assign rd     = inst[11:7];
  assign f3     = inst[14:12];
  assign f7_5   = inst[30];
  assign imm_i  = {{(DATA_W-12){inst[31]}}, inst[31:20]};
  assign imm_s  = {{(DATA_W-12){inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_u  = {inst[31:12], 12'b0};

  always_comb begin
    entry          = '0;
    entry.control  = ALU_ADD;
    entry.pc       = pc;
    entry.rs2_data = rs2_data;
    entry.rd       = rd;
    wr             = 1'b1;

    case (opcode)
      OP_OP: begin
        entry.in_a    = rs1_data;
        entry.in_b    = rs2_data;
        entry.control = f3_to_ctrl(f3, f7_5);
        if (f3 == 3'b010 || f3 == 3'b011) entry.cmp_mode = f3;
        if (f3 == 3'b101)                 entry.sra      = f7_5;
      end
      OP_IMM: begin
        entry.in_a    = rs1_data;
        entry.in_b    = imm_i;
        entry.control = f3_to_ctrl(f3, 1'b0);
        if (f3 == 3'b010 || f3 == 3'b011) entry.cmp_mode = f3;
        // Shift immediates carry only the shamt; funct7 bits must not leak into b.
        if (f3 == 3'b001 || f3 == 3'b101) begin
          entry.in_b      = '0;
          entry.in_b[4:0] = inst[24:20];
        end
        if (f3 == 3'b101) entry.sra = inst[30];
      end
      OP_LUI: begin
        entry.in_b = imm_u;
      end
      OP_AUIPC: begin
        entry.in_a = pc;
        entry.in_b = imm_u;
      end
      OP_JAL, OP_JALR: begin
        entry.in_a = pc;
        entry.in_b = DATA_W'(4);
      end
      OP_BRANCH: begin
        entry.in_a     = rs1_data;
        entry.in_b     = rs2_data;
        entry.control  = ALU_SUB;
        entry.cmp_mode = f3;
        wr             = 1'b0;
      end
      OP_LOAD: begin
        entry.in_a = rs1_data;
        entry.in_b = imm_i;
      end
      OP_STORE: begin
        entry.in_a = rs1_data;
        entry.in_b = imm_s;
        wr         = 1'b0;
      end
      default: begin
        entry.illegal = 1'b1;
        wr            = 1'b0;
      end
    endcase

    entry.rd_we = wr & (rd != 5'd0);
  end

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX issue stage feeding the ALU. Decodes an incoming instruction and
// holds it in a two-entry buffer (main + skid) so in_ready depends only on
// registered state. Issue latency is one cycle; order is preserved.
//   clock, reset         : clock, synchronous active-low reset
//   in_valid/in_ready    : upstream handshake
//   in_pc, in_inst       : instruction PC and word
//   in_rs1_data/rs2_data : forwarded register operands
//   flush                : drop both buffered entries
//   out_valid/out_ready  : downstream handshake (main entry)
//   out_in_a/in_b/control: ALU operands and control code
//   out_pc, out_rs2_data, out_rd, out_rd_we, out_cmp_mode, out_sra,
//   out_illegal          : side fields for EX/WB
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_rs1_data,
  input  logic [XLEN-1:0] in_rs2_data,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_in_a,
  output logic [XLEN-1:0] out_in_b,
  output logic [2:0]      out_control,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_rs2_data,
  output logic [4:0]      out_rd,
  output logic            out_rd_we,
  output logic [2:0]      out_cmp_mode,
  output logic            out_sra,
  output logic            out_illegal
);

  issue_entry_t dec_entry;
  issue_entry_t main_q;
  issue_entry_t skid_q;
  logic         main_v;
  logic         skid_v;
  logic         accept;
  logic         pop;

  alu_issue_decode u_decode (
    .inst     (in_inst),
    .pc       (in_pc),
    .rs1_data (in_rs1_data),
    .rs2_data (in_rs2_data),
    .entry    (dec_entry)
  );

  function automatic issue_entry_t reset_entry();
    issue_entry_t e;
    e    = '0;
    e.pc = RESET_PC;
    return e;
  endfunction

  assign in_ready = reset & ~skid_v;
  assign accept   = in_valid & in_ready;
  assign pop      = main_v & out_ready;

  // The skid can only be occupied while main is full, so an empty main
  // never has a pending skid entry behind it.
  always_ff @(posedge clock) begin
    if (!reset) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
      main_q <= reset_entry();
      skid_q <= '0;
    end else if (flush) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
    end else if (!main_v || pop) begin
      if (skid_v) begin
        main_q <= skid_q;
        main_v <= 1'b1;
        skid_v <= 1'b0;
      end else begin
        main_v <= accept;
        if (accept) main_q <= dec_entry;
      end
    end else if (accept) begin
      skid_q <= dec_entry;
      skid_v <= 1'b1;
    end
  end

  assign out_valid    = main_v;
  assign out_in_a     = main_q.in_a;
  assign out_in_b     = main_q.in_b;
  assign out_control  = main_q.control;
  assign out_pc       = main_q.pc;
  assign out_rs2_data = main_q.rs2_data;
  assign out_rd       = main_q.rd;
  assign out_rd_we    = main_q.rd_we;
  assign out_cmp_mode = main_q.cmp_mode;
  assign out_sra      = main_q.sra;
  assign out_illegal  = main_q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
module tb_alu_issue_stage;

  localparam logic [31:0] RST_PC = 32'h0000_8000;

  localparam logic [6:0] O_OP  = 7'b0110011, O_IMM = 7'b0010011, O_LUI = 7'b0110111,
                         O_AUI = 7'b0010111, O_JAL = 7'b1101111, O_BR  = 7'b1100011,
                         O_LD  = 7'b0000011, O_ST  = 7'b0100011;

  logic        clock = 1'b0;
  logic        reset, in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0] in_pc, in_inst, in_rs1_data, in_rs2_data;
  logic [31:0] out_in_a, out_in_b, out_pc, out_rs2_data;
  logic [2:0]  out_control, out_cmp_mode;
  logic [4:0]  out_rd;
  logic        out_rd_we, out_sra, out_illegal;

  int checks = 0;
  int errors = 0;

  alu_issue_stage #(.XLEN(32), .RESET_PC(RST_PC)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_inst(in_inst),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_in_a(out_in_a), .out_in_b(out_in_b), .out_control(out_control),
    .out_pc(out_pc), .out_rs2_data(out_rs2_data), .out_rd(out_rd),
    .out_rd_we(out_rd_we), .out_cmp_mode(out_cmp_mode), .out_sra(out_sra),
    .out_illegal(out_illegal)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {f7, rs2, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [6:0] op);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], op};
  endfunction

  function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd, input logic [6:0] op);
    return {imm, rd, op};
  endfunction

  task automatic expect_out(input string tag, input logic v, input logic [31:0] a, input logic [31:0] b,
                            input logic [2:0] c, input logic [4:0] rd, input logic we,
                            input logic [2:0] cmp, input logic sra, input logic ill);
    check({tag, ".valid"}, {31'b0, out_valid}, {31'b0, v});
    check({tag, ".a"}, out_in_a, a);
    check({tag, ".b"}, out_in_b, b);
    check({tag, ".ctrl"}, {29'b0, out_control}, {29'b0, c});
    check({tag, ".rd"}, {27'b0, out_rd}, {27'b0, rd});
    check({tag, ".we"}, {31'b0, out_rd_we}, {31'b0, we});
    check({tag, ".cmp"}, {29'b0, out_cmp_mode}, {29'b0, cmp});
    check({tag, ".sra"}, {31'b0, out_sra}, {31'b0, sra});
    check({tag, ".ill"}, {31'b0, out_illegal}, {31'b0, ill});
  endtask

  // Drive one instruction with out_ready=1; it must appear on the next edge.
  task automatic run_vec(input string tag, input logic [31:0] inst, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] c, input logic [4:0] rd, input logic we,
                         input logic [2:0] cmp, input logic sra, input logic ill);
    in_valid = 1'b1;
    in_inst  = inst;
    step();
    expect_out(tag, 1'b1, a, b, c, rd, we, cmp, sra, ill);
    check({tag, ".pc"}, out_pc, 32'h40);
    check({tag, ".rs2d"}, out_rs2_data, 32'd7);
  endtask

  task automatic drive(input logic [31:0] pc, input logic [31:0] rs1);
    in_valid    = 1'b1;
    in_pc       = pc;
    in_rs1_data = rs1;
    in_inst     = enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd3, O_OP);
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    in_pc = '0; in_inst = '0; in_rs1_data = '0; in_rs2_data = '0;
    step();
    step();
    check("rst.in_ready", {31'b0, in_ready}, 32'd0);
    expect_out("rst", 1'b0, 32'd0, 32'd0, 3'b000, 5'd0, 1'b0, 3'b000, 1'b0, 1'b0);
    check("rst.pc", out_pc, RST_PC);
    check("rst.rs2d", out_rs2_data, 32'd0);

    reset = 1'b1;
    #1;
    check("rst_rel.in_ready", {31'b0, in_ready}, 32'd1);

    // Streaming decode vectors.
    out_ready = 1'b1; in_pc = 32'h40; in_rs1_data = 32'd5; in_rs2_data = 32'd7;
    run_vec("add",   enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd3, O_OP), 32'd5, 32'd7, 3'b000, 5'd3, 1'b1, 3'b000, 1'b0, 1'b0);
    run_vec("sub",   enc_r(7'h20, 5'd2, 5'd1, 3'b000, 5'd3, O_OP), 32'd5, 32'd7, 3'b010, 5'd3, 1'b1, 3'b000, 1'b0, 1'b0);
    run_vec("sltu",  enc_r(7'h00, 5'd2, 5'd1, 3'b011, 5'd4, O_OP), 32'd5, 32'd7, 3'b010, 5'd4, 1'b1, 3'b011, 1'b0, 1'b0);
    run_vec("srl",   enc_r(7'h00, 5'd2, 5'd1, 3'b101, 5'd7, O_OP), 32'd5, 32'd7, 3'b101, 5'd7, 1'b1, 3'b000, 1'b0, 1'b0);
    run_vec("and",   enc_r(7'h00, 5'd2, 5'd1, 3'b111, 5'd9, O_OP), 32'd5, 32'd7, 3'b111, 5'd9, 1'b1, 3'b000, 1'b0, 1'b0);
    run_vec("srai",  enc_i(12'h403, 5'd1, 3'b101, 5'd5, O_IMM),    32'd5, 32'd3, 3'b101, 5'd5, 1'b1, 3'b000, 1'b1, 1'b0);
    run_vec("slli",  enc_i(12'h01F, 5'd1, 3'b001, 5'd5, O_IMM),    32'd5, 32'd31, 3'b001, 5'd5, 1'b1, 3'b000, 1'b0, 1'b0);
    run_vec("addi",  enc_i(12'hFFF, 5'd1, 3'b000, 5'd6, O_IMM),    32'd5, 32'hFFFF_FFFF, 3'b000, 5'd6, 1'b1, 3'b000, 1'b0, 1'b0);
    run_vec("slti",  enc_i(12'h00A, 5'd1, 3'b010, 5'd6, O_IMM),    32'd5, 32'd10, 3'b010, 5'd6, 1'b1, 3'b010, 1'b0, 1'b0);
    run_vec("xori",  enc_i(12'h0F0, 5'd1, 3'b100, 5'd10, O_IMM),   32'd5, 32'hF0, 3'b100, 5'd10, 1'b1, 3'b000, 1'b0, 1'b0);
    run_vec("lui0",  enc_u(20'h12345, 5'd0, O_LUI),                32'd0, 32'h1234_5000, 3'b000, 5'd0, 1'b0, 3'b000, 1'b0, 1'b0);
    run_vec("auipc", enc_u(20'h00001, 5'd8, O_AUI),                32'h40, 32'h1000, 3'b000, 5'd8, 1'b1, 3'b000, 1'b0, 1'b0);
    run_vec("jal",   enc_u(20'h00010, 5'd1, O_JAL),                32'h40, 32'd4, 3'b000, 5'd1, 1'b1, 3'b000, 1'b0, 1'b0);
    run_vec("blt",   enc_s(12'h008, 5'd2, 5'd1, 3'b100, O_BR),     32'd5, 32'd7, 3'b010, 5'd8, 1'b0, 3'b100, 1'b0, 1'b0);
    run_vec("sw",    enc_s(12'h008, 5'd2, 5'd1, 3'b010, O_ST),     32'd5, 32'd8, 3'b000, 5'd8, 1'b0, 3'b000, 1'b0, 1'b0);
    run_vec("lw",    enc_i(12'hFFC, 5'd1, 3'b010, 5'd9, O_LD),     32'd5, 32'hFFFF_FFFC, 3'b000, 5'd9, 1'b1, 3'b000, 1'b0, 1'b0);
    run_vec("illeg", 32'h0000_00FF,                                32'd0, 32'd0, 3'b000, 5'd1, 1'b0, 3'b000, 1'b0, 1'b1);
    in_valid = 1'b0;
    step();
    check("drain.valid", {31'b0, out_valid}, 32'd0);

    // Back-pressure: A, B buffered, C held off until the stage drains.
    out_ready = 1'b0;
    drive(32'h100, 32'd1); step();
    check("bp.a.pc", out_pc, 32'h100);
    check("bp.a.ready", {31'b0, in_ready}, 32'd1);
    drive(32'h104, 32'd2); step();
    check("bp.b.pc_hold", out_pc, 32'h100);
    check("bp.b.ready", {31'b0, in_ready}, 32'd0);
    drive(32'h108, 32'd3); step();
    check("bp.c.pc_hold", out_pc, 32'h100);
    check("bp.c.a_hold", out_in_a, 32'd1);
    check("bp.c.valid", {31'b0, out_valid}, 32'd1);
    out_ready = 1'b1; step();
    check("bp.rel1.pc", out_pc, 32'h104);
    check("bp.rel1.a", out_in_a, 32'd2);
    check("bp.rel1.ready", {31'b0, in_ready}, 32'd1);
    step();
    check("bp.rel2.pc", out_pc, 32'h108);
    check("bp.rel2.a", out_in_a, 32'd3);
    in_valid = 1'b0; step();
    check("bp.empty", {31'b0, out_valid}, 32'd0);

    // Flush with both entries full and input valid.
    out_ready = 1'b0;
    drive(32'h200, 32'd4); step();
    drive(32'h204, 32'd5); step();
    check("fl.full.ready", {31'b0, in_ready}, 32'd0);
    drive(32'h208, 32'd6); flush = 1'b1; step();
    check("fl.valid", {31'b0, out_valid}, 32'd0);
    check("fl.ready", {31'b0, in_ready}, 32'd1);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; step();
    check("fl.after.valid", {31'b0, out_valid}, 32'd0);

    // Flush beats a same-cycle accept into the skid.
    out_ready = 1'b0;
    drive(32'h300, 32'd7); step();
    drive(32'h304, 32'd8); flush = 1'b1; step();
    check("fl2.valid", {31'b0, out_valid}, 32'd0);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; step();
    check("fl2.after.valid", {31'b0, out_valid}, 32'd0);

    // Reset mid-stream.
    out_ready = 1'b0;
    drive(32'h400, 32'd9); step();
    check("mr.pre.valid", {31'b0, out_valid}, 32'd1);
    drive(32'h404, 32'd10); reset = 1'b0;
    #1;
    check("mr.low.ready", {31'b0, in_ready}, 32'd0);
    step();
    expect_out("mr", 1'b0, 32'd0, 32'd0, 3'b000, 5'd0, 1'b0, 3'b000, 1'b0, 1'b0);
    check("mr.pc", out_pc, RST_PC);
    check("mr.rs2d", out_rs2_data, 32'd0);
    check("mr.ready", {31'b0, in_ready}, 32'd0);
    reset = 1'b1; in_valid = 1'b0;
    #1;
    check("mr.rel.ready", {31'b0, in_ready}, 32'd1);
    out_ready = 1'b1; step();
    check("mr.after.valid", {31'b0, out_valid}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
